// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding, address field widths and field extraction for the MEM-stage data cache.
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;
  localparam int LINES_DEF = 16;
  localparam int OFFSET_W = 5;
  localparam int WORD_SEL_W = 3;
  localparam int IDX_W = $clog2(LINES_DEF);
  localparam int TAG_W = 32 - OFFSET_W - IDX_W;
  function automatic logic [WORD_SEL_W-1:0] word_sel(input logic [31:0] addr);
    return addr[OFFSET_W-1:2];
  endfunction
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w);
    return (addr >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
  endfunction
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
    return addr >> (OFFSET_W + idx_w);
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data storage with one read port and one refill-or-store write port.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int LINE_W = 256,
  parameter int TW     = 23
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(LINES)-1:0] idx,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  output logic [TW-1:0]            rd_tag,
  output logic [LINE_W-1:0]        rd_line,
  input  logic                     refill_we,
  input  logic [TW-1:0]            refill_tag,
  input  logic [LINE_W-1:0]        refill_line,
  input  logic                     store_we,
  input  logic [WORD_SEL_W-1:0]    store_sel,
  input  logic [31:0]              store_word
);
  logic [LINES-1:0] valid, dirty;
  logic [TW-1:0] tag_arr [LINES];
  logic [LINE_W-1:0] data_arr [LINES];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag = tag_arr[idx];
  assign rd_line = data_arr[idx];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (refill_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (store_we) dirty[idx] <= 1'b1;
  // Tag and data contents are don't-care until valid is set, so they carry no reset.
  always_ff @(posedge clk_i)
    if (refill_we) begin
      tag_arr[idx] <= refill_tag;
      data_arr[idx] <= refill_line;
    end else if (store_we) data_arr[idx][{store_sel, 5'b0} +: 32] <= store_word;
endmodule

// File: rtl/mem_dcache_ctrl.sv
// mem_dcache_ctrl: direct-mapped write-back write-allocate data cache controller for the MEM stage.
module mem_dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);
  localparam int IDX = $clog2(LINES);
  localparam int TW = ADDR_W - OFFSET_W - IDX;
  state_t state;
  logic req, hit, evict, rd_valid, rd_dirty;
  logic [IDX-1:0] idx;
  logic [TW-1:0] tag, rd_tag;
  logic [WORD_SEL_W-1:0] ws;
  logic [LINE_W-1:0] rd_line;
  assign req = cpu_MemRead_i | cpu_MemWrite_i;
  assign idx = IDX'(addr_index(cpu_addr_i, IDX));
  assign tag = TW'(addr_tag(cpu_addr_i, IDX));
  assign ws = word_sel(cpu_addr_i);
  assign hit = req & rd_valid & (rd_tag == tag);
  assign evict = rd_valid & rd_dirty;
  // Stall is masked while reset is asserted so upstream is released immediately.
  assign cpu_stall_o = rst_i & ((state == IDLE) ? (req & ~hit) : 1'b1);
  assign cpu_rdata_o = (state == IDLE && hit && cpu_MemRead_i && !cpu_MemWrite_i) ? rd_line[{ws, 5'b0} +: 32] : '0;
  dcache_sram #(.LINES(LINES), .LINE_W(LINE_W), .TW(TW)) u_sram (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .idx(idx),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag(rd_tag),
    .rd_line(rd_line),
    .refill_we(state == REFILL && mem_ack_i),
    .refill_tag(tag),
    .refill_line(mem_rdata_i),
    .store_we(state == IDLE && hit && cpu_MemWrite_i),
    .store_sel(ws),
    .store_word(cpu_wdata_i)
  );
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
    end else
      case (state)
        IDLE: if (req && !hit) begin
          state <= evict ? WRITEBACK : REFILL;
          mem_enable_o <= 1'b1;
          mem_write_o <= evict;
          mem_addr_o <= {evict ? rd_tag : tag, idx, {OFFSET_W{1'b0}}};
          mem_wdata_o <= evict ? rd_line : '0;
        end
        WRITEBACK: if (mem_ack_i) begin
          state <= REFILL;
          mem_write_o <= 1'b0;
          mem_addr_o <= {tag, idx, {OFFSET_W{1'b0}}};
          mem_wdata_o <= '0;
        end
        REFILL: if (mem_ack_i) begin
          state <= DONE;
          mem_enable_o <= 1'b0;
          mem_addr_o <= '0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_dcache_ctrl.sv
// tb_mem_dcache_ctrl: directed scenarios against mem_dcache_ctrl with the bench acting as off-chip memory.
module tb_mem_dcache_ctrl;
  logic clk = 0, rst_i = 0, rd = 0, wr = 0, ack = 0;
  logic [31:0] addr = '0, wdata = '0, rdata, mem_addr;
  logic [255:0] mem_wdata, mem_rdata = '0;
  logic stall, en, mwr;
  logic [255:0] l1, l2, l3, evicted;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  mem_dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr), .cpu_addr_i(addr),
    .cpu_wdata_i(wdata), .cpu_rdata_o(rdata), .cpu_stall_o(stall), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_enable_o(en), .mem_write_o(mwr), .mem_rdata_i(mem_rdata), .mem_ack_i(ack)
  );
  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] w1);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    l[63:32] = w1;
    return l;
  endfunction
  // Plays memory for one miss: acks the write-back after wb_wait enabled cycles and the refill after rf_wait.
  task automatic serve(input logic exp_wb, input int wb_wait, input int rf_wait, input logic [255:0] line,
      output int stalls, output logic wb_wr, output logic [31:0] wb_addr, output logic [255:0] wb_data,
      output logic [31:0] rf_addr, output logic rf_wr, output logic stable);
    int nw, nr;
    logic in_wb;
    stalls = 0; nw = 0; nr = 0; in_wb = exp_wb; stable = 1;
    wb_wr = 0; wb_addr = '0; wb_data = '0; rf_addr = '0; rf_wr = 1;
    @(negedge clk);
    while (stall && stalls < 200) begin
      stalls++;
      if (en && in_wb) begin
        if (nw == 0) begin wb_wr = mwr; wb_addr = mem_addr; wb_data = mem_wdata; end
        else if (mem_addr !== wb_addr) stable = 0;
        nw++;
        if (nw == wb_wait) begin ack = 1; in_wb = 0; end
      end else if (en) begin
        if (nr == 0) begin rf_addr = mem_addr; rf_wr = mwr; end
        else if (mem_addr !== rf_addr || mwr !== rf_wr) stable = 0;
        nr++;
        if (nr == rf_wait) begin mem_rdata = line; ack = 1; end
      end
      @(posedge clk); #1 ack = 0;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%h exp=0", stall); else passed++;
    total++; if (en !== 1'b0 || mwr !== 1'b0) $display("FAIL reset_mem_ctl got=%b%b exp=00", en, mwr); else passed++;
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 256'h0) $display("FAIL reset_mem_bus got=%h exp=0", mem_addr); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata); else passed++;
    @(posedge clk); #1 rst_i = 1;
  endtask
  task automatic test_cold_load;
    int n; logic wbw, rfw, st; logic [31:0] wa, ra; logic [255:0] wd;
    @(posedge clk); #1 rd = 1; wr = 0; addr = 32'h104;
    serve(0, 0, 1, l1, n, wbw, wa, wd, ra, rfw, st);
    total++; if (n !== 3) $display("FAIL cold_stall_cycles got=%0d exp=3", n); else passed++;
    total++; if (ra !== 32'h100) $display("FAIL cold_refill_addr got=%h exp=00000100", ra); else passed++;
    total++; if (rfw !== 1'b0) $display("FAIL cold_refill_write got=%b exp=0", rfw); else passed++;
    total++; if (rdata !== 32'hDEADBEEF) $display("FAIL cold_rdata got=%h exp=deadbeef", rdata); else passed++;
    total++; if (stall !== 1'b0 || en !== 1'b0) $display("FAIL cold_idle got=%b%b exp=00", stall, en); else passed++;
  endtask
  task automatic test_store_hit;
    @(posedge clk); #1 rd = 0; wr = 1; addr = 32'h108; wdata = 32'h12345678;
    @(negedge clk);
    total++; if (stall !== 1'b0 || en !== 1'b0) $display("FAIL store_hit_stall got=%b%b exp=00", stall, en); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL store_rdata got=%h exp=0", rdata); else passed++;
    @(posedge clk); #1 rd = 1; wr = 1; addr = 32'h10C; wdata = 32'h000055AA;
    @(negedge clk);
    total++; if (stall !== 1'b0 || rdata !== 32'h0) $display("FAIL both_is_store got=%b/%h exp=0/0", stall, rdata); else passed++;
    @(posedge clk); #1 rd = 1; wr = 0; addr = 32'h108;
    @(negedge clk);
    total++; if (rdata !== 32'h12345678 || stall !== 1'b0) $display("FAIL load_after_store got=%h exp=12345678", rdata); else passed++;
    @(posedge clk); #1 addr = 32'h10C;
    @(negedge clk);
    total++; if (rdata !== 32'h000055AA) $display("FAIL load_after_both got=%h exp=000055aa", rdata); else passed++;
  endtask
  task automatic test_dirty_evict;
    int n; logic wbw, rfw, st; logic [31:0] wa, ra; logic [255:0] wd;
    @(posedge clk); #1 rd = 1; wr = 0; addr = 32'h304;
    serve(1, 2, 3, l2, n, wbw, wa, wd, ra, rfw, st);
    total++; if (wbw !== 1'b1) $display("FAIL evict_wb_write got=%b exp=1", wbw); else passed++;
    total++; if (wa !== 32'h100) $display("FAIL evict_wb_addr got=%h exp=00000100", wa); else passed++;
    total++; if (wd !== evicted) $display("FAIL evict_wb_data got=%h exp=%h", wd, evicted); else passed++;
    total++; if (ra !== 32'h300 || rfw !== 1'b0) $display("FAIL evict_refill got=%h/%b exp=00000300/0", ra, rfw); else passed++;
    total++; if (n !== 7) $display("FAIL evict_stall_cycles got=%0d exp=7", n); else passed++;
    total++; if (rdata !== 32'hCAFEF00D) $display("FAIL evict_rdata got=%h exp=cafef00d", rdata); else passed++;
  endtask
  task automatic test_clean_evict;
    int n; logic wbw, rfw, st; logic [31:0] wa, ra; logic [255:0] wd;
    @(posedge clk); #1 rd = 1; wr = 0; addr = 32'h104;
    serve(0, 0, 1, evicted, n, wbw, wa, wd, ra, rfw, st);
    total++; if (n !== 3) $display("FAIL clean_stall_cycles got=%0d exp=3", n); else passed++;
    total++; if (ra !== 32'h100 || rfw !== 1'b0) $display("FAIL clean_refill got=%h/%b exp=00000100/0", ra, rfw); else passed++;
    total++; if (rdata !== 32'hDEADBEEF) $display("FAIL clean_rdata got=%h exp=deadbeef", rdata); else passed++;
  endtask
  task automatic test_mem_stall;
    int n; logic wbw, rfw, st; logic [31:0] wa, ra; logic [255:0] wd;
    @(posedge clk); #1 rd = 1; wr = 0; addr = 32'h204;
    serve(0, 0, 10, l3, n, wbw, wa, wd, ra, rfw, st);
    total++; if (n !== 12) $display("FAIL slow_stall_cycles got=%0d exp=12", n); else passed++;
    total++; if (st !== 1'b1 || ra !== 32'h200) $display("FAIL slow_refill_stable got=%b/%h exp=1/00000200", st, ra); else passed++;
    total++; if (rdata !== 32'h0BADC0DE) $display("FAIL slow_rdata got=%h exp=0badc0de", rdata); else passed++;
    @(posedge clk); #1 rd = 0;
    @(negedge clk); ack = 1;
    @(posedge clk); #1 ack = 0;
    @(negedge clk);
    total++; if (en !== 1'b0 || stall !== 1'b0) $display("FAIL spurious_ack got=%b%b exp=00", en, stall); else passed++;
    @(posedge clk); #1 rd = 1; addr = 32'h204;
    @(negedge clk);
    total++; if (stall !== 1'b0 || rdata !== 32'h0BADC0DE) $display("FAIL spurious_ack_hit got=%b/%h exp=0/0badc0de", stall, rdata); else passed++;
  endtask
  task automatic test_reset_mid_refill;
    int n; logic wbw, rfw, st; logic [31:0] wa, ra; logic [255:0] wd;
    @(posedge clk); #1 rd = 1; wr = 0; addr = 32'h404;
    @(posedge clk); @(negedge clk);
    total++; if (en !== 1'b1 || mem_addr !== 32'h400) $display("FAIL mid_refill_active got=%b/%h exp=1/00000400", en, mem_addr); else passed++;
    rst_i = 0;
    #1;
    total++; if (en !== 1'b0 || stall !== 1'b0) $display("FAIL async_reset got=%b%b exp=00", en, stall); else passed++;
    @(posedge clk); #1 addr = 32'h204; rst_i = 1;
    serve(0, 0, 1, l3, n, wbw, wa, wd, ra, rfw, st);
    total++; if (n !== 3 || ra !== 32'h200) $display("FAIL post_reset_miss got=%0d/%h exp=3/00000200", n, ra); else passed++;
    total++; if (rdata !== 32'h0BADC0DE) $display("FAIL post_reset_rdata got=%h exp=0badc0de", rdata); else passed++;
  endtask
  initial begin
    l1 = mk_line(32'hA000_0000, 32'hDEADBEEF);
    l2 = mk_line(32'hB000_0000, 32'hCAFEF00D);
    l3 = mk_line(32'hC000_0000, 32'h0BADC0DE);
    evicted = l1;
    evicted[95:64] = 32'h12345678;
    evicted[127:96] = 32'h000055AA;
    test_reset;
    test_cold_load;
    test_store_hit;
    test_dirty_evict;
    test_clean_evict;
    test_mem_stall;
    test_reset_mid_refill;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
